// File: rtl/fp_add_pkg.sv
// Shared types for the FP adder exponent path: compare verdicts, comparator FSM states,
// and the decode of a cascade seed into a verdict.
package fp_add_pkg;
  localparam int EXP_W = 8;

  typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // "less" wins over "greater", so a malformed seed still yields a single verdict
  function automatic cmp_e seed_decode(input logic l, input logic g);
    if (l)      return CMP_LT;
    else if (g) return CMP_GT;
    else        return CMP_EQ;
  endfunction
endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Operand/seed request and verdict response handshakes of the serial magnitude comparator.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = fp_add_pkg::EXP_W
);
  localparam int BW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             l_in;
  logic             e_in;
  logic             g_in;
  logic             out_valid;
  logic             out_ready;
  logic             l_out;
  logic             e_out;
  logic             g_out;
  logic [BW-1:0]    bits_used;

  modport slave (
    input  in_valid, a, b, l_in, e_in, g_in, out_ready,
    output in_ready, out_valid, l_out, e_out, g_out, bits_used
  );

  modport master (
    output in_valid, a, b, l_in, e_in, g_in, out_ready,
    input  in_ready, out_valid, l_out, e_out, g_out, bits_used
  );
endinterface

// File: rtl/serial_magnitude_comparator_cell.sv
// One-bit cascadable magnitude compare cell: a decided less/greater from above passes
// through, otherwise the local bit pair decides.
module comparator_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_l,
  input  logic i_e,
  input  logic i_g,
  output logic o_l,
  output logic o_e,
  output logic o_g
);
  assign o_l = i_l | (i_e & ~i_a & i_b);
  assign o_g = ~i_l & (i_g | (i_e & i_a & ~i_b));
  assign o_e = ~i_l & ~i_g & i_e & ~(i_a ^ i_b);
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator: one bit per cycle through a single compare
// cell, stopping at the first differing bit; a decided seed skips the scan entirely.
module serial_magnitude_comparator
  import fp_add_pkg::*;
#(
  parameter int WIDTH = EXP_W
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_magnitude_comparator_if.slave  bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int BW = $clog2(WIDTH + 1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [BW-1:0]    r_bits, w_bits_nxt;
  cmp_e             r_cmp, w_cmp_nxt;
  cmp_e             w_seed;
  logic             w_l, w_e, w_g;
  logic             w_done;

  // Cascade state feeds the cell; during a scan it is EQ until the first mismatch
  comparator_1bit u_cell (
    .i_a (r_a[r_idx]),
    .i_b (r_b[r_idx]),
    .i_l (r_cmp == CMP_LT),
    .i_e (r_cmp == CMP_EQ),
    .i_g (r_cmp == CMP_GT),
    .o_l (w_l),
    .o_e (w_e),
    .o_g (w_g)
  );

  assign w_seed = seed_decode(bus.l_in, bus.g_in);

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_idx_nxt   = r_idx;
    w_bits_nxt  = r_bits;
    w_cmp_nxt   = r_cmp;
    case (r_state)
      IDLE: if (bus.in_valid) begin
        w_a_nxt     = bus.a;
        w_b_nxt     = bus.b;
        w_idx_nxt   = IW'(WIDTH - 1);
        w_bits_nxt  = '0;
        w_cmp_nxt   = w_seed;
        w_state_nxt = (w_seed == CMP_EQ) ? SHIFT : DONE;
      end
      SHIFT: begin
        w_bits_nxt = r_bits + BW'(1);
        w_cmp_nxt  = w_l ? CMP_LT : (w_g ? CMP_GT : CMP_EQ);
        // idx never decrements past zero: the last bit always terminates the scan
        if (!w_e || r_idx == '0) w_state_nxt = DONE;
        else                     w_idx_nxt   = r_idx - IW'(1);
      end
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_bits  <= '0;
      r_cmp   <= CMP_EQ;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_idx   <= w_idx_nxt;
      r_bits  <= w_bits_nxt;
      r_cmp   <= w_cmp_nxt;
    end
  end

  assign w_done        = (r_state == DONE);
  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = w_done;
  assign bus.l_out     = w_done && (r_cmp == CMP_LT);
  assign bus.e_out     = w_done && (r_cmp == CMP_EQ);
  assign bus.g_out     = w_done && (r_cmp == CMP_GT);
  assign bus.bits_used = r_bits;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: the driver queues hand-computed verdicts at issue time, a negedge
// monitor pops and compares on every output handshake.
module tb_serial_magnitude_comparator;
  import fp_add_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_magnitude_comparator_if #(.WIDTH(8)) bus ();
  serial_magnitude_comparator #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int leg;
    int bits;
    int lat;
  } exp_t;

  exp_t q[$];
  exp_t m_exp;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   first_edge = 0;
  int   hs_edge = 0;
  logic prev_ov = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Edge numbers: posedge k sets cyc=k; a negedge sample decides what happens at cyc+1
  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) acc_edge = cyc + 1;
    if (bus.out_valid && !prev_ov) first_edge = cyc;
    prev_ov = bus.out_valid;
    if (bus.out_valid && bus.out_ready) begin
      hs_edge = cyc + 1;
      if (q.size() == 0) begin
        check("unexpected_output", int'(bus.out_valid), 0);
      end else begin
        m_exp = q.pop_front();
        check("verdict", int'({bus.l_out, bus.e_out, bus.g_out}), m_exp.leg);
        check("bits_used", int'(bus.bits_used), m_exp.bits);
        check("latency", first_edge - acc_edge + 1, m_exp.lat);
      end
    end
  end

  // leg is {l,e,g}: LT=4, EQ=2, GT=1
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic l, input logic e, input logic g,
                      input bit push, input int leg, input int bits, input int lat);
    int n;
    @(posedge clk); #1;
    bus.a = a; bus.b = b; bus.l_in = l; bus.e_in = e; bus.g_in = g;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", int'(bus.in_ready), 1);
    else if (push) q.push_back('{leg, bits, lat});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !bus.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", q.size(), 0);
  endtask

  // Hold off the consumer for 5 DONE cycles while the verdict must stay frozen
  task automatic stall();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", int'(bus.out_valid), 1);
      check("stall_verdict", int'({bus.l_out, bus.e_out, bus.g_out}), 1);
      check("stall_in_ready", int'(bus.in_ready), 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.l_in = 1'b0; bus.e_in = 1'b1; bus.g_in = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_verdict", int'({bus.l_out, bus.e_out, bus.g_out}), 0);
    check("rst_bits_used", int'(bus.bits_used), 0);
    #1 rst = 1'b0;

    send(8'hA5, 8'h25, 0, 1, 0, 1, 1, 1, 2);
    send(8'h3C, 8'h3C, 0, 1, 0, 1, 2, 8, 9);
    send(8'h10, 8'h11, 0, 1, 0, 1, 4, 8, 9);
    send(8'h7F, 8'h80, 0, 1, 0, 1, 4, 1, 2);
    send(8'hFF, 8'h00, 1, 0, 0, 1, 4, 0, 1);
    send(8'h00, 8'hFF, 1, 0, 1, 1, 4, 0, 1);
    send(8'h00, 8'hFF, 0, 0, 1, 1, 1, 0, 1);
    send(8'hFF, 8'hFE, 0, 0, 0, 1, 1, 8, 9);
    drain();

    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(8'hC0, 8'h80, 0, 1, 0, 1, 1, 2, 3);
    fork
      send(8'h05, 8'h06, 0, 1, 0, 1, 4, 7, 8);
      stall();
    join
    check("accept_after_handshake", acc_edge, hs_edge + 1);
    drain();

    send(8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 0);
    n = 0;
    while (bus.bits_used != 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_bit3", int'(bus.bits_used), 3);
    #1 rst = 1'b1;
    #1;
    check("t6_in_ready", int'(bus.in_ready), 0);
    check("t6_out_valid", int'(bus.out_valid), 0);
    check("t6_verdict", int'({bus.l_out, bus.e_out, bus.g_out}), 0);
    check("t6_bits_used", int'(bus.bits_used), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'h01, 8'h00, 0, 1, 0, 1, 1, 8, 9);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
